// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV64I opcode constants, decode classes and immediate formats
package riscv_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // OC_NONE is zero so the reset value of the decode register is all-zero
    typedef enum logic [3:0] {
        OC_NONE      = 4'd0,
        OC_LUI       = 4'd1,
        OC_AUIPC     = 4'd2,
        OC_JAL       = 4'd3,
        OC_JALR      = 4'd4,
        OC_BRANCH    = 4'd5,
        OC_LOAD      = 4'd6,
        OC_STORE     = 4'd7,
        OC_OP_IMM    = 4'd8,
        OC_OP        = 4'd9,
        OC_OP_IMM_32 = 4'd10,
        OC_OP_32     = 4'd11,
        OC_MISC_MEM  = 4'd12,
        OC_SYSTEM    = 4'd13
    } opclass_e;

    typedef enum logic [2:0] {
        IMM_Z = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_fmt_e;

    // Every format fits in 32 bits sign-extended from bit 31; callers widen to XLEN
    function automatic logic [31:0] imm32(input logic [31:0] ins, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm32 = {ins[31:12], 12'h000};
            IMM_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm32 = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32 x XLEN integer register file, two async read ports, one write port
module regfile
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/idecode.sv
// rtl/idecode.sv - RV64I decode stage with register read, writeback bypass and decode register
module idecode
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            instr_valid,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_current,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_pc,
    output logic [4:0]      dec_rs1,
    output logic [4:0]      dec_rs2,
    output logic [4:0]      dec_rd,
    output logic [XLEN-1:0] dec_rs1_data,
    output logic [XLEN-1:0] dec_rs2_data,
    output logic [XLEN-1:0] dec_imm,
    output opclass_e        dec_opclass,
    output logic [2:0]      dec_funct3,
    output logic            dec_alt,
    output logic            dec_rd_we,
    output logic            dec_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rf_a, rf_b, rs1_val, rs2_val, imm_n;
    logic [31:0]     imm_lo;
    opclass_e        opclass_n;
    imm_fmt_e        fmt;
    logic            writes_rd, illegal_n, rd_we_n;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign rd     = instruction[11:7];

    regfile #(.XLEN(XLEN)) u_regfile (
        .clk     (clk),
        .resetn  (resetn),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs1),
        .rdata_a (rf_a),
        .raddr_b (rs2),
        .rdata_b (rf_b)
    );

    // A write landing this cycle is not yet in the array, so forward it
    assign rs1_val = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1)) ? wb_data : rf_a;
    assign rs2_val = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2)) ? wb_data : rf_b;

    // Every listed opcode ends in 2'b11, so non-32-bit encodings fall into default
    always_comb begin
        opclass_n = OC_NONE;
        fmt       = IMM_Z;
        writes_rd = 1'b0;
        illegal_n = 1'b0;
        case (opcode)
            OPC_LUI:       begin opclass_n = OC_LUI;       fmt = IMM_U; writes_rd = 1'b1; end
            OPC_AUIPC:     begin opclass_n = OC_AUIPC;     fmt = IMM_U; writes_rd = 1'b1; end
            OPC_JAL:       begin opclass_n = OC_JAL;       fmt = IMM_J; writes_rd = 1'b1; end
            OPC_JALR: begin
                opclass_n = OC_JALR;   fmt = IMM_I; writes_rd = 1'b1;
                illegal_n = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                opclass_n = OC_BRANCH; fmt = IMM_B;
                illegal_n = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                opclass_n = OC_LOAD;   fmt = IMM_I; writes_rd = 1'b1;
                illegal_n = (funct3 == 3'b111);
            end
            OPC_STORE: begin
                opclass_n = OC_STORE;  fmt = IMM_S;
                illegal_n = funct3[2];
            end
            OPC_OP_IMM:    begin opclass_n = OC_OP_IMM;    fmt = IMM_I; writes_rd = 1'b1; end
            OPC_OP_IMM_32: begin opclass_n = OC_OP_IMM_32; fmt = IMM_I; writes_rd = 1'b1; end
            OPC_OP, OPC_OP_32: begin
                opclass_n = (opcode == OPC_OP) ? OC_OP : OC_OP_32;
                writes_rd = 1'b1;
                illegal_n = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OPC_MISC_MEM:  opclass_n = OC_MISC_MEM;
            OPC_SYSTEM:    begin opclass_n = OC_SYSTEM;    fmt = IMM_I; end
            default:       illegal_n = 1'b1;
        endcase
        if (illegal_n) begin
            opclass_n = OC_NONE;
            writes_rd = 1'b0;
        end
    end

    assign rd_we_n = writes_rd && (rd != 5'd0);
    assign imm_lo  = imm32(instruction, fmt);
    assign imm_n   = {{(XLEN-32){imm_lo[31]}}, imm_lo};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dec_valid    <= 1'b0;
            dec_pc       <= '0;
            dec_rs1      <= '0;
            dec_rs2      <= '0;
            dec_rd       <= '0;
            dec_rs1_data <= '0;
            dec_rs2_data <= '0;
            dec_imm      <= '0;
            dec_opclass  <= OC_NONE;
            dec_funct3   <= '0;
            dec_alt      <= 1'b0;
            dec_rd_we    <= 1'b0;
            dec_illegal  <= 1'b0;
        end else if (flush) begin
            dec_valid    <= 1'b0;
            dec_rd_we    <= 1'b0;
            dec_illegal  <= 1'b0;
        end else if (stall) begin
            // Held operands must not go stale while writeback retires their producers
            if (dec_valid && wb_en) begin
                if ((dec_rs1 != 5'd0) && (wb_rd == dec_rs1)) dec_rs1_data <= wb_data;
                if ((dec_rs2 != 5'd0) && (wb_rd == dec_rs2)) dec_rs2_data <= wb_data;
            end
        end else if (instr_valid) begin
            dec_valid    <= 1'b1;
            dec_pc       <= pc_current;
            dec_rs1      <= rs1;
            dec_rs2      <= rs2;
            dec_rd       <= rd;
            dec_rs1_data <= rs1_val;
            dec_rs2_data <= rs2_val;
            dec_imm      <= imm_n;
            dec_opclass  <= opclass_n;
            dec_funct3   <= funct3;
            dec_alt      <= instruction[30];
            dec_rd_we    <= rd_we_n;
            dec_illegal  <= illegal_n;
        end else begin
            dec_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idecode.sv
// tb/tb_idecode.sv - self-checking bench for idecode: vector table, directed corners, random vs model
module tb_idecode;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, instr_valid, stall, flush, wb_en;
    logic [31:0] instruction;
    logic [63:0] pc_current, wb_data;
    logic [4:0]  wb_rd;
    logic        dec_valid, dec_alt, dec_rd_we, dec_illegal;
    logic [63:0] dec_pc, dec_rs1_data, dec_rs2_data, dec_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [2:0]  dec_funct3;
    opclass_e    dec_opclass;

    always #5 clk = ~clk;

    idecode #(.XLEN(64)) dut (
        .clk(clk), .resetn(resetn), .instr_valid(instr_valid), .instruction(instruction),
        .pc_current(pc_current), .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_rs1(dec_rs1),
        .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rs1_data(dec_rs1_data),
        .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm), .dec_opclass(dec_opclass),
        .dec_funct3(dec_funct3), .dec_alt(dec_alt), .dec_rd_we(dec_rd_we),
        .dec_illegal(dec_illegal)
    );

    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] rs1_data, rs2_data, imm;
        opclass_e    opclass;
        logic [2:0]  funct3;
        logic        alt, rd_we, illegal;
    } dec_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
        opclass_e    oc;
        logic [63:0] imm;
        logic        rd_we;
        logic        ill;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    dec_t        m;
    logic [63:0] regs [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m.valid = 0; m.pc = 0; m.rs1 = 0; m.rs2 = 0; m.rd = 0;
        m.rs1_data = 0; m.rs2_data = 0; m.imm = 0; m.opclass = OC_NONE;
        m.funct3 = 0; m.alt = 0; m.rd_we = 0; m.illegal = 0;
        for (int i = 0; i < 32; i++) regs[i] = 0;
    endtask

    // Reference decode: immediates by signed arithmetic on the whole word
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [63:0] pc,
                                        input logic [63:0] v1, input logic [63:0] v2);
        dec_t   d;
        longint sx, sgn;
        logic   wr, ill;
        logic [2:0] f3;
        sx  = longint'($signed(ins));
        sgn = sx >>> 31;
        f3  = ins[14:12];
        wr  = 0; ill = 0;
        d.imm = 0; d.opclass = OC_NONE;
        case (ins[6:0])
            7'h37: begin d.opclass = OC_LUI;   wr = 1; d.imm = sx & 64'hFFFF_FFFF_FFFF_F000; end
            7'h17: begin d.opclass = OC_AUIPC; wr = 1; d.imm = sx & 64'hFFFF_FFFF_FFFF_F000; end
            7'h6F: begin
                d.opclass = OC_JAL; wr = 1;
                d.imm = sgn * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                        + longint'(ins[30:21]) * 2;
            end
            7'h67: begin d.opclass = OC_JALR; wr = 1; ill = (f3 != 0); d.imm = sx >>> 20; end
            7'h63: begin
                d.opclass = OC_BRANCH; ill = (f3 == 2) || (f3 == 3);
                d.imm = sgn * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                        + longint'(ins[11:8]) * 2;
            end
            7'h03: begin d.opclass = OC_LOAD; wr = 1; ill = (f3 == 7); d.imm = sx >>> 20; end
            7'h23: begin
                d.opclass = OC_STORE; ill = (f3 >= 4);
                d.imm = (sx >>> 25) * 32 + longint'(ins[11:7]);
            end
            7'h13: begin d.opclass = OC_OP_IMM;    wr = 1; d.imm = sx >>> 20; end
            7'h1B: begin d.opclass = OC_OP_IMM_32; wr = 1; d.imm = sx >>> 20; end
            7'h33, 7'h3B: begin
                d.opclass = (ins[6:0] == 7'h33) ? OC_OP : OC_OP_32; wr = 1;
                ill = !(ins[31:25] == 7'h00 || ins[31:25] == 7'h20);
            end
            7'h0F: d.opclass = OC_MISC_MEM;
            7'h73: begin d.opclass = OC_SYSTEM; d.imm = sx >>> 20; end
            default: ill = 1;
        endcase
        if (ill) d.opclass = OC_NONE;
        d.valid = 1; d.pc = pc; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
        d.rs1_data = v1; d.rs2_data = v2; d.funct3 = f3; d.alt = ins[30];
        d.illegal = ill; d.rd_we = wr && !ill && (ins[11:7] != 0);
        return d;
    endfunction

    function automatic logic [63:0] operand(input logic [4:0] r, input logic we,
                                            input logic [4:0] wrd, input logic [63:0] wd);
        if (r == 0) return 0;
        if (we && wrd == r) return wd;
        return regs[r];
    endfunction

    task automatic check_all();
        chk("dec_valid", 64'(dec_valid), 64'(m.valid));
        if (m.valid) begin
            chk("dec_pc", dec_pc, m.pc);
            chk("dec_rs1", 64'(dec_rs1), 64'(m.rs1));
            chk("dec_rs2", 64'(dec_rs2), 64'(m.rs2));
            chk("dec_rd", 64'(dec_rd), 64'(m.rd));
            chk("dec_rs1_data", dec_rs1_data, m.rs1_data);
            chk("dec_rs2_data", dec_rs2_data, m.rs2_data);
            chk("dec_imm", dec_imm, m.imm);
            chk("dec_opclass", 64'(dec_opclass), 64'(m.opclass));
            chk("dec_funct3", 64'(dec_funct3), 64'(m.funct3));
            chk("dec_alt", 64'(dec_alt), 64'(m.alt));
            chk("dec_rd_we", 64'(dec_rd_we), 64'(m.rd_we));
            chk("dec_illegal", 64'(dec_illegal), 64'(m.illegal));
        end
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare
    task automatic step(input logic iv, input logic [31:0] ins, input logic [63:0] pc,
                        input logic st, input logic fl, input logic we,
                        input logic [4:0] wrd, input logic [63:0] wd);
        instr_valid = iv; instruction = ins; pc_current = pc;
        stall = st; flush = fl; wb_en = we; wb_rd = wrd; wb_data = wd;
        if (fl) begin
            m.valid = 0; m.rd_we = 0; m.illegal = 0;
        end else if (st) begin
            if (m.valid && we) begin
                if (m.rs1 != 0 && wrd == m.rs1) m.rs1_data = wd;
                if (m.rs2 != 0 && wrd == m.rs2) m.rs2_data = wd;
            end
        end else if (iv) begin
            m = ref_decode(ins, pc, operand(ins[19:15], we, wrd, wd), operand(ins[24:20], we, wrd, wd));
        end else begin
            m.valid = 0;
        end
        if (we && wrd != 0) regs[wrd] = wd;
        @(posedge clk); #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 14))
            0: w[6:0] = 7'h37;   1: w[6:0] = 7'h17;   2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;   4: w[6:0] = 7'h63;   5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;   7: w[6:0] = 7'h13;   8: w[6:0] = 7'h1B;
            9: w[6:0] = 7'h33;  10: w[6:0] = 7'h3B;  11: w[6:0] = 7'h0F;
            12: w[6:0] = 7'h73; 13: w[6:0] = 7'h33;  default: ;
        endcase
        if ((w[6:0] == 7'h33 || w[6:0] == 7'h3B) && $urandom_range(0, 3) != 0)
            w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        if ((w[6:0] == 7'h67) && $urandom_range(0, 1)) w[14:12] = 3'b000;
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[11:7]  = 5'($urandom_range(0, 7));
        return w;
    endfunction

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{32'h00500093, 64'h8000_0000, OC_OP_IMM,    64'd5,                   1'b1, 1'b0};
        tbl[1]  = '{32'hFE000EE3, 64'h8000_0004, OC_BRANCH,    64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0};
        tbl[2]  = '{32'h00000000, 64'h8000_0008, OC_NONE,      64'd0,                   1'b0, 1'b1};
        tbl[3]  = '{32'h123452B7, 64'h8000_000C, OC_LUI,       64'h0000_0000_1234_5000, 1'b1, 1'b0};
        tbl[4]  = '{32'hFE112C23, 64'h8000_0010, OC_STORE,     64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0};
        tbl[5]  = '{32'h008000EF, 64'h8000_0014, OC_JAL,       64'd8,                   1'b1, 1'b0};
        tbl[6]  = '{32'h000010E7, 64'h8000_0018, OC_NONE,      64'd0,                   1'b0, 1'b1};
        tbl[7]  = '{32'h00007083, 64'h8000_001C, OC_NONE,      64'd0,                   1'b0, 1'b1};
        tbl[8]  = '{32'h00003083, 64'h8000_0020, OC_LOAD,      64'd0,                   1'b1, 1'b0};
        tbl[9]  = '{32'h02000033, 64'h8000_0024, OC_NONE,      64'd0,                   1'b0, 1'b1};
        tbl[10] = '{32'hFFF0809B, 64'h8000_0028, OC_OP_IMM_32, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        tbl[11] = '{32'h00000001, 64'h8000_002C, OC_NONE,      64'd0,                   1'b0, 1'b1};
        tbl[12] = '{32'h0FF0000F, 64'h8000_0030, OC_MISC_MEM,  64'd0,                   1'b0, 1'b0};
        tbl[13] = '{32'hFFFFF117, 64'h8000_0034, OC_AUIPC,     64'hFFFF_FFFF_FFFF_F000, 1'b1, 1'b0};

        resetn = 0; instr_valid = 0; instruction = 0; pc_current = 0;
        stall = 0; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        reset_model();
        @(posedge clk); @(posedge clk); #1;
        chk("reset dec_valid", 64'(dec_valid), 64'd0);
        chk("reset dec_pc", dec_pc, 64'd0);
        chk("reset dec_imm", dec_imm, 64'd0);
        chk("reset dec_opclass", 64'(dec_opclass), 64'(OC_NONE));
        chk("reset dec_rd_we", 64'(dec_rd_we), 64'd0);
        resetn = 1;

        for (int i = 0; i < 14; i++) begin
            step(1, tbl[i].ins, tbl[i].pc, 0, 0, 0, 0, 0);
            chk("tbl valid", 64'(dec_valid), 64'd1);
            chk("tbl pc", dec_pc, tbl[i].pc);
            chk("tbl opclass", 64'(dec_opclass), 64'(tbl[i].oc));
            chk("tbl imm", dec_imm, tbl[i].imm);
            chk("tbl rd_we", 64'(dec_rd_we), 64'(tbl[i].rd_we));
            chk("tbl illegal", 64'(dec_illegal), 64'(tbl[i].ill));
        end

        step(1, 32'h002101B3, 64'h8000_0100, 0, 0, 1, 5'd2, 64'h1234);
        chk("bypass rs1", dec_rs1_data, 64'h1234);
        chk("bypass rs2", dec_rs2_data, 64'h1234);
        chk("bypass rd", 64'(dec_rd), 64'd3);

        step(1, 32'h00500093, 64'h8000_1000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, rand_instr(), 64'h9000_0000, 1, 0, 1, 5'd7, 64'hDEAD);
            chk("stall pc", dec_pc, 64'h8000_1000);
            chk("stall imm", dec_imm, 64'd5);
            chk("stall valid", 64'(dec_valid), 64'd1);
        end
        step(1, 32'h00500093, 64'h8000_2000, 1, 1, 0, 0, 0);
        chk("flush valid", 64'(dec_valid), 64'd0);
        chk("flush rd_we", 64'(dec_rd_we), 64'd0);
        chk("flush illegal", 64'(dec_illegal), 64'd0);

        step(1, 32'h002101B3, 64'h8000_3000, 0, 0, 0, 0, 0);
        chk("pre-stall rs1", dec_rs1_data, 64'h1234);
        step(0, 0, 0, 1, 0, 1, 5'd2, 64'h55);
        chk("stall fwd rs1", dec_rs1_data, 64'h55);
        chk("stall fwd rs2", dec_rs2_data, 64'h55);
        step(0, 0, 0, 1, 0, 1, 5'd0, 64'h77);
        chk("stall x0 ignored", dec_rs1_data, 64'h55);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, rand_instr(), {$urandom, $urandom} & ~64'h3,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
        end

        step(1, 32'h00500093, 64'h8000_4000, 0, 0, 1, 5'd2, 64'hABCD);
        chk("pre-reset valid", 64'(dec_valid), 64'd1);
        #3 resetn = 0;
        #1;
        chk("async reset valid", 64'(dec_valid), 64'd0);
        chk("async reset pc", dec_pc, 64'd0);
        chk("async reset opclass", 64'(dec_opclass), 64'(OC_NONE));
        reset_model();
        @(posedge clk); #1;
        resetn = 1;
        step(1, 32'h002101B3, 64'h8000_5000, 0, 0, 0, 0, 0);
        chk("post-reset x2 rs1", dec_rs1_data, 64'd0);
        chk("post-reset valid", 64'(dec_valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
